// File: rtl/sram1rw_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram1rw_arbiter_pkg
//  Description : Shared constants and types for the two-requester arbiter
//                in front of a 128x12 single-port SRAM macro.
//                  DEPTH / ADDR_W / DATA_W : macro geometry
//                  state_t                 : controller states (INIT, SERVE)
//                  issue_t                 : fields of one granted access
//  Revision    : 1.0  initial release
// ============================================================================
package sram1rw_arbiter_pkg;

    localparam int DEPTH  = 128;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DATA_W = 12;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              id;
    } issue_t;

endpackage
`default_nettype wire

// File: rtl/sram1rw_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram1rw_arbiter_if
//  Description : Request/response bus between the two requesters and the
//                arbiter. Vectors are packed per requester (bit/slice r
//                belongs to requester r).
//                  req_valid/req_ready/req_we  : handshake and direction
//                  req_addr/req_wdata          : packed address and data
//                  rsp_valid/rsp_rdata         : read response, no backpressure
//                modport master = requester side, slave = arbiter side.
//  Revision    : 1.0  initial release
// ============================================================================
interface sram1rw_arbiter_if;
    import sram1rw_arbiter_pkg::*;

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface
`default_nettype wire

// File: rtl/sram1rw_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-input round-robin arbiter. Grant is combinational; the
//                last_grant flop only moves on an actual grant, so a lone
//                requester can win on consecutive cycles.
//                  clk, rst_n : clock, async active-low reset
//                  en         : arbitration allowed (grant forced to 0 if low)
//                  valid[1:0] : per-requester request
//                  grant[1:0] : one-hot (or zero) grant
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       en,
    input  wire logic [1:0] valid,
    output logic      [1:0] grant
);

    logic r_last_grant;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // Contention: the requester that did not win last time goes.
                2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Reset value 1 means requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (|grant) begin
            r_last_grant <= grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram1rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram1rw_arbiter
//  Description : Shares one single-port SRAM macro between requester 0 (core)
//                and requester 1 (debug/DMA). After reset every word is
//                cleared to INIT_VALUE, then one access per cycle is granted
//                round-robin. Macro strobes are registered; read data comes
//                back two cycles after the accept.
//                  clk, rst_n   : clock (also macro CE), async active-low reset
//                  bus          : request/response bus (slave side)
//                  init_done    : clear sweep complete
//                  sram_csb/web/oeb : active-low chip select / write / read
//                  sram_a, sram_i   : macro address / write data
//                  sram_o           : macro read data (registered in macro)
//  Revision    : 1.0  initial release
// ============================================================================
module sram1rw_arbiter
    import sram1rw_arbiter_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    sram1rw_arbiter_if.slave          bus,
    output logic                      init_done,
    output logic                      sram_csb,
    output logic                      sram_web,
    output logic                      sram_oeb,
    output logic [ADDR_W-1:0]         sram_a,
    output logic [DATA_W-1:0]         sram_i,
    input  wire logic [DATA_W-1:0]    sram_o
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
    logic                r_init_done, w_init_done_nxt;
    logic                r_csb, w_csb_nxt;
    logic                r_web, w_web_nxt;
    logic                r_oeb, w_oeb_nxt;
    logic [ADDR_W-1:0]   r_a, w_a_nxt;
    logic [DATA_W-1:0]   r_i, w_i_nxt;

    // Read-tracking shift: stage 0 is the cycle the macro pins are driven,
    // stage 1 is the cycle the macro output is valid.
    logic                r_rd0_vld, w_rd0_vld_nxt;
    logic                r_rd0_id,  w_rd0_id_nxt;
    logic                r_rd1_vld;
    logic                r_rd1_id;

    logic                w_serve;
    logic [1:0]          w_grant;
    logic                w_accept;
    issue_t              w_issue;

    assign w_serve = (r_state == SERVE);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_serve),
        .valid (bus.req_valid),
        .grant (w_grant)
    );

    assign bus.req_ready = w_grant;
    assign w_accept      = |w_grant;

    // Select the granted requester's fields; grant is one-hot when accepting.
    always_comb begin
        w_issue.id = w_grant[1];
        if (w_grant[1]) begin
            w_issue.we    = bus.req_we[1];
            w_issue.addr  = bus.req_addr[2*ADDR_W-1:ADDR_W];
            w_issue.wdata = bus.req_wdata[2*DATA_W-1:DATA_W];
        end else begin
            w_issue.we    = bus.req_we[0];
            w_issue.addr  = bus.req_addr[ADDR_W-1:0];
            w_issue.wdata = bus.req_wdata[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-pin logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_init_done_nxt = r_init_done;
        w_csb_nxt       = 1'b1;
        w_web_nxt       = 1'b1;
        w_oeb_nxt       = 1'b1;
        w_a_nxt         = r_a;
        w_i_nxt         = r_i;
        w_rd0_vld_nxt   = 1'b0;
        w_rd0_id_nxt    = r_rd0_id;

        case (r_state)
            INIT: begin
                w_csb_nxt = 1'b0;
                w_web_nxt = 1'b0;
                w_a_nxt   = r_cnt;
                w_i_nxt   = INIT_VALUE;
                // Counter parks on the last address instead of wrapping.
                if (r_cnt == c_LAST_ADDR) begin
                    w_state_nxt     = SERVE;
                    w_init_done_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_W'(1);
                end
            end
            SERVE: begin
                if (w_accept) begin
                    w_csb_nxt = 1'b0;
                    w_a_nxt   = w_issue.addr;
                    if (w_issue.we) begin
                        w_web_nxt = 1'b0;
                        w_i_nxt   = w_issue.wdata;
                    end else begin
                        w_oeb_nxt     = 1'b0;
                        w_rd0_vld_nxt = 1'b1;
                        w_rd0_id_nxt  = w_issue.id;
                    end
                end
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered macro pins, init counter and read tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_csb       <= 1'b1;
            r_web       <= 1'b1;
            r_oeb       <= 1'b1;
            r_a         <= '0;
            r_i         <= '0;
            r_rd0_vld   <= 1'b0;
            r_rd0_id    <= 1'b0;
            r_rd1_vld   <= 1'b0;
            r_rd1_id    <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_init_done <= w_init_done_nxt;
            r_csb       <= w_csb_nxt;
            r_web       <= w_web_nxt;
            r_oeb       <= w_oeb_nxt;
            r_a         <= w_a_nxt;
            r_i         <= w_i_nxt;
            r_rd0_vld   <= w_rd0_vld_nxt;
            r_rd0_id    <= w_rd0_id_nxt;
            r_rd1_vld   <= r_rd0_vld;
            r_rd1_id    <= r_rd0_id;
        end
    end

    assign init_done     = r_init_done;
    assign sram_csb      = r_csb;
    assign sram_web      = r_web;
    assign sram_oeb      = r_oeb;
    assign sram_a        = r_a;
    assign sram_i        = r_i;

    assign bus.rsp_valid = r_rd1_vld ? (r_rd1_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_rdata = sram_o;

endmodule
`default_nettype wire
